// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters (ALU, MEM) and the write arbiter.
// The arbiter takes the slave side; the requesters and the regfile take master.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              in0_valid;
  logic              in0_ready;
  logic [3:0]        in0_reg;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid;
  logic              in1_ready;
  logic [3:0]        in1_reg;
  logic [DATA_W-1:0] in1_data;
  logic              wr_en;
  logic [3:0]        wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       pending_mask;

  modport master (
    output in0_valid, in0_reg, in0_data,
    output in1_valid, in1_reg, in1_data,
    input  in0_ready, in1_ready,
    input  wr_en, wr_reg, wr_data, pending_mask
  );

  modport slave (
    input  in0_valid, in0_reg, in0_data,
    input  in1_valid, in1_reg, in1_data,
    output in0_ready, in1_ready,
    output wr_en, wr_reg, wr_data, pending_mask
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter for the single register-file write port.
// One pending slot per port, round-robin grant, oldest-first on same reg.
module regfile_write_arbiter #(
  parameter int DATA_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  logic              v0, v1;
  logic [3:0]        r0, r1;
  logic [DATA_W-1:0] d0, d1;
  logic              last;
  logic              age;
  logic              g0, g1;
  logic              ld0, ld1;
  logic              en_q;
  logic [3:0]        reg_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       pm;

  // age=1: slot 1 older; last=1: port 1 granted last
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      (v0 && !v1): g0 = 1'b1;
      (v1 && !v0): g1 = 1'b1;
      (v0 && v1 && r0 == r1): begin
        g0 = !age;
        g1 = age;
      end
      (v0 && v1 && r0 != r1): begin
        g0 = last;
        g1 = !last;
      end
      default: ;
    endcase
  end

  assign bus.in0_ready = !rst && (!v0 || g0);
  assign bus.in1_ready = !rst && (!v1 || g1);

  // Register 0 transfers complete the handshake but never load a slot
  assign ld0 = bus.in0_valid && bus.in0_ready
            && (bus.in0_reg != 4'd0);
  assign ld1 = bus.in1_valid && bus.in1_ready
            && (bus.in1_reg != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      v0     <= 1'b0;
      v1     <= 1'b0;
      r0     <= '0;
      r1     <= '0;
      d0     <= '0;
      d1     <= '0;
      last   <= 1'b1;
      age    <= 1'b0;
      en_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      if (ld0) begin
        v0 <= 1'b1;
        r0 <= bus.in0_reg;
        d0 <= bus.in0_data;
      end else if (g0) begin
        v0 <= 1'b0;
      end
      if (ld1) begin
        v1 <= 1'b1;
        r1 <= bus.in1_reg;
        d1 <= bus.in1_data;
      end else if (g1) begin
        v1 <= 1'b0;
      end
      if (ld0 && ld1) begin
        age <= 1'b0;
      end else if (ld0 && v1 && !g1) begin
        age <= 1'b1;
      end else if (ld1 && v0 && !g0) begin
        age <= 1'b0;
      end
      if (g0 || g1) begin
        last <= g1;
      end
      en_q <= g0 || g1;
      if (g0) begin
        reg_q  <= r0;
        data_q <= d0;
      end else if (g1) begin
        reg_q  <= r1;
        data_q <= d1;
      end
    end
  end

  always_comb begin
    pm = '0;
    if (v0) pm[r0] = 1'b1;
    if (v1) pm[r1] = 1'b1;
    if (en_q) pm[reg_q] = 1'b1;
    pm[0] = 1'b0;
  end

  assign bus.wr_en        = en_q;
  assign bus.wr_reg       = reg_q;
  assign bus.wr_data      = data_q;
  assign bus.pending_mask = pm;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
// Expected writes are queued at issue; a monitor checks each wr_en cycle.
module tb_regfile_write_arbiter;
  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];

  regfile_write_arbiter_if #(.DATA_W(16)) bus();

  regfile_write_arbiter #(.DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic expect_wr(input logic [3:0] r, input logic [15:0] d);
    exp_t e;
    e.r = r;
    e.d = d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      exp_t e;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got reg %0d data %h expected none",
                 bus.wr_reg, bus.wr_data);
      end else begin
        e = q.pop_front();
        if (bus.wr_reg !== e.r || bus.wr_data !== e.d) begin
          miscompares++;
          $display("FAIL write: got reg %0d data %h expected reg %0d data %h",
                   bus.wr_reg, bus.wr_data, e.r, e.d);
        end
      end
    end
  end

  task automatic cyc(input logic a0, input logic [3:0] ra,
                     input logic [15:0] da, input logic a1,
                     input logic [3:0] rb, input logic [15:0] db);
    @(posedge clk);
    #1;
    bus.in0_valid = a0;
    bus.in0_reg   = ra;
    bus.in0_data  = da;
    bus.in1_valid = a1;
    bus.in1_reg   = rb;
    bus.in1_data  = db;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    idle();
    check(nm, 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    @(negedge clk);
    check("ready_in_reset", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in0_valid = 1'b0;
    bus.in0_reg   = 4'd0;
    bus.in0_data  = 16'h0;
    bus.in1_valid = 1'b0;
    bus.in1_reg   = 4'd0;
    bus.in1_data  = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check("ready_in_reset", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_wr_en", 32'(bus.wr_en), 32'd0);
    check("reset_wr_reg", 32'(bus.wr_reg), 32'd0);
    check("reset_wr_data", 32'(bus.wr_data), 32'd0);
    check("reset_pending", 32'(bus.pending_mask), 32'd0);

    // single write
    expect_wr(4'd5, 16'h1234);
    cyc(1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0);
    check("single_ready", 32'(bus.in0_ready), 32'd1);
    check("single_pm_pre", 32'(bus.pending_mask), 32'h0);
    idle();
    check("single_pm_e0", 32'(bus.pending_mask), 32'h20);
    check("single_no_wr_yet", 32'(bus.wr_en), 32'd0);
    idle();
    check("single_pm_e1", 32'(bus.pending_mask), 32'h20);
    check("single_wr_en", 32'(bus.wr_en), 32'd1);
    idle();
    check("single_pm_e2", 32'(bus.pending_mask), 32'h0);

    // register 0 drop
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF);
    check("r0_ready", 32'(bus.in1_ready), 32'd1);
    idle();
    check("r0_pm", 32'(bus.pending_mask), 32'h0);
    idle();
    check("r0_pm2", 32'(bus.pending_mask), 32'h0);
    check("r0_no_wr", 32'(bus.wr_en), 32'd0);

    // contention from reset: grants 3,7,3,7,3,7,3
    do_reset();
    for (int i = 0; i < 7; i++)
      expect_wr((i % 2 == 0) ? 4'd3 : 4'd7,
                (i % 2 == 0) ? 16'h3333 : 16'h7777);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 4'd3, 16'h3333, 1'b1, 4'd7, 16'h7777);
      if (k == 0)
        check("cont_rdy_k0", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd3);
      else if (k % 2 == 1)
        check("cont_rdy_odd", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd2);
      else
        check("cont_rdy_even", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd1);
    end
    drain("cont_drain");

    // same reg: port 1 first, one cycle ahead (last grant was port 0)
    expect_wr(4'd9, 16'hAAAA);
    expect_wr(4'd9, 16'hBBBB);
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'hAAAA);
    cyc(1'b1, 4'd9, 16'hBBBB, 1'b0, 4'd0, 16'h0);
    drain("same_seq_drain");

    // same reg, same edge, last grant port 0: age picks port 0 anyway
    expect_wr(4'd9, 16'hCCCC);
    expect_wr(4'd9, 16'hDDDD);
    cyc(1'b1, 4'd9, 16'hCCCC, 1'b1, 4'd9, 16'hDDDD);
    idle();
    check("same_pm", 32'(bus.pending_mask), 32'h200);
    drain("same_edge_drain");

    // drain/reload back-to-back on port 0
    for (int i = 1; i <= 4; i++)
      expect_wr(4'(i), 16'(i * 16'h11));
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 4'(i), 16'(i * 16'h11), 1'b0, 4'd0, 16'h0);
      check("reload_ready", 32'(bus.in0_ready), 32'd1);
      if (i >= 3) check("reload_wr_en", 32'(bus.wr_en), 32'd1);
    end
    idle();
    check("reload_wr_en", 32'(bus.wr_en), 32'd1);
    idle();
    check("reload_wr_en", 32'(bus.wr_en), 32'd1);
    drain("reload_drain");

    // reset mid-operation drops both buffered writes
    cyc(1'b1, 4'd4, 16'h4444, 1'b1, 4'd6, 16'h6666);
    check("mid_ready", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    @(negedge clk);
    check("mid_pm_loaded", 32'(bus.pending_mask), 32'h50);
    check("mid_ready_rst", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_wr_en", 32'(bus.wr_en), 32'd0);
    check("mid_pm", 32'(bus.pending_mask), 32'h0);
    repeat (4) idle();

    // first tie after reset goes to port 0
    expect_wr(4'd10, 16'h0A0A);
    expect_wr(4'd11, 16'h0B0B);
    cyc(1'b1, 4'd10, 16'h0A0A, 1'b1, 4'd11, 16'h0B0B);
    idle();
    check("tie_pm", 32'(bus.pending_mask), 32'h0C00);
    drain("tie_drain");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
